// File: rtl/project_pwm_shadow_sequencer_pkg.sv
// Shared definitions for the PWM compare shadow sequencer.
// Holds the per-channel state encodings, the load-mode codes,
// the compare-index codes and the event qualification helper.
package project_pwm_shadow_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PENDING = 2'b01,
        ST_ARMED   = 2'b10
    } st_e;

    localparam logic [1:0] LM_IMM    = 2'b00;
    localparam logic [1:0] LM_ZERO   = 2'b01;
    localparam logic [1:0] LM_PERIOD = 2'b10;
    localparam logic [1:0] LM_BOTH   = 2'b11;

    localparam logic [1:0] IDX_ACMPA = 2'd0;
    localparam logic [1:0] IDX_ACMPB = 2'd1;
    localparam logic [1:0] IDX_BCMPA = 2'd2;
    localparam logic [1:0] IDX_BCMPB = 2'd3;

    // An armed channel loads when its selected counter event fires.
    // Immediate mode while armed loads without waiting. Zero and period
    // together in LM_BOTH still yield a single load.
    function automatic logic evt_qualifies(input logic [1:0] mode,
                                           input logic       zero,
                                           input logic       period);
        return (mode == LM_IMM) ||
               ((mode == LM_ZERO)   && zero) ||
               ((mode == LM_PERIOD) && period) ||
               ((mode == LM_BOTH)   && (zero || period));
    endfunction

endpackage

// File: rtl/project_pwm_shadow_channel.sv
// One PWM channel's double buffer: four shadow compare registers written
// by the host, four active registers seen by the comparators, and the
// IDLE/PENDING/ARMED commit FSM with counter-event qualification.
// Active registers in o_cmp are ordered A.compa, A.compb, B.compa, B.compb
// from the LSB up.
module project_pwm_shadow_channel
    import project_pwm_shadow_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wr_en,
    input  logic [1:0]         i_wr_idx,
    input  logic [WIDTH-1:0]   i_wr_data,
    input  logic               i_arm,
    input  logic               i_abort,
    input  logic [1:0]         i_mode,
    input  logic               i_zero_evt,
    input  logic               i_period_evt,
    output logic [4*WIDTH-1:0] o_cmp,
    output logic [1:0]         o_state,
    output logic               o_load_done
);

    st_e                   st_q, st_d;
    logic [3:0][WIDTH-1:0] shadow_q, shadow_d;
    logic [3:0][WIDTH-1:0] active_q, active_d;
    logic                  load_done_q, load_done_d;

    // Next state: the write lands in the shadow first, so a same-cycle
    // arm commits the freshly written value (loads copy shadow_d).
    always_comb begin
        st_d        = st_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        load_done_d = 1'b0;
        if (i_wr_en) begin
            shadow_d[i_wr_idx] = i_wr_data;
            if (st_q == ST_IDLE) st_d = ST_PENDING;
        end
        case (st_q)
            ST_IDLE, ST_PENDING: begin
                if (i_arm && (i_wr_en || (st_q == ST_PENDING))) begin
                    if (i_mode == LM_IMM) begin
                        active_d    = shadow_d;
                        st_d        = ST_IDLE;
                        load_done_d = 1'b1;
                    end else begin
                        st_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (i_abort) begin
                    st_d = ST_PENDING;
                end else if (evt_qualifies(i_mode, i_zero_evt, i_period_evt)) begin
                    active_d    = shadow_d;
                    st_d        = ST_IDLE;
                    load_done_d = 1'b1;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // State, shadow and active registers; reset discards pending data.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            st_q        <= ST_IDLE;
            shadow_q    <= '0;
            active_q    <= '0;
            load_done_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            load_done_q <= load_done_d;
        end
    end

    assign o_cmp       = active_q;
    assign o_state     = st_q;
    assign o_load_done = load_done_q;

endmodule

// File: rtl/project_pwm_shadow_sequencer.sv
// PWM compare shadow sequencer top: decodes host shadow writes, stalls
// writes to armed channels, flags writes to nonexistent channels, and
// fans arm/mode/events out to one shadow channel per PWM channel.
// Optional macro SHADOW_SYNC_COMMIT_EN: i_arm[0] arms every pending
// channel and all channels commit on channel 0's mode and events.
module project_pwm_shadow_sequencer
    import project_pwm_shadow_sequencer_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_wr_valid,
    output logic                      o_wr_ready,
    input  logic [1:0]                i_wr_ch,
    input  logic [1:0]                i_wr_idx,
    input  logic [WIDTH-1:0]          i_wr_data,
    input  logic [NUM_CH-1:0]         i_arm,
    input  logic [NUM_CH-1:0]         i_abort,
    input  logic [2*NUM_CH-1:0]       i_load_mode,
    input  logic [NUM_CH-1:0]         i_zero_evt,
    input  logic [NUM_CH-1:0]         i_period_evt,
    output logic [4*WIDTH*NUM_CH-1:0] o_cmp,
    output logic [2*NUM_CH-1:0]       o_state,
    output logic [NUM_CH-1:0]         o_load_done,
    output logic                      o_err
);

    logic [NUM_CH-1:0][1:0] ch_state;
    logic                   ch_ok;
    logic                   wr_acc;
    logic                   err_q, err_d;

    assign ch_ok = (32'(i_wr_ch) < 32'(NUM_CH));

    // Stall only when the addressed channel is waiting on its commit event.
    always_comb begin
        o_wr_ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if ((i_wr_ch == 2'(c)) && (ch_state[c] == ST_ARMED)) o_wr_ready = 1'b0;
        end
    end

    assign wr_acc = i_wr_valid && o_wr_ready;

    // Out-of-range writes are accepted and dropped, with a one-cycle error.
    always_comb begin
        err_d = wr_acc && !ch_ok;
    end

    // Error pulse register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign o_err   = err_q;
    assign o_state = ch_state;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic       wr_en, arm_c, zero_c, period_c;
        logic [1:0] mode_c;

        assign wr_en = wr_acc && ch_ok && (i_wr_ch == 2'(c));
`ifdef SHADOW_SYNC_COMMIT_EN
        assign arm_c    = i_arm[c] || i_arm[0];
        assign mode_c   = i_load_mode[1:0];
        assign zero_c   = i_zero_evt[0];
        assign period_c = i_period_evt[0];
`else
        assign arm_c    = i_arm[c];
        assign mode_c   = i_load_mode[2*c +: 2];
        assign zero_c   = i_zero_evt[c];
        assign period_c = i_period_evt[c];
`endif

        project_pwm_shadow_channel #(.WIDTH(WIDTH)) u_ch (
            .i_clk        (i_clk),
            .i_reset      (i_reset),
            .i_wr_en      (wr_en),
            .i_wr_idx     (i_wr_idx),
            .i_wr_data    (i_wr_data),
            .i_arm        (arm_c),
            .i_abort      (i_abort[c]),
            .i_mode       (mode_c),
            .i_zero_evt   (zero_c),
            .i_period_evt (period_c),
            .o_cmp        (o_cmp[c*4*WIDTH +: 4*WIDTH]),
            .o_state      (ch_state[c]),
            .o_load_done  (o_load_done[c])
        );
    end

endmodule

// File: tb/tb_project_pwm_shadow_sequencer.sv
// Bench for project_pwm_shadow_sequencer: directed stimulus, a reference
// model built from shadow/active arrays plus dirty/armed flags, a
// per-cycle compare on the falling edge, and literal spot checks.
module tb_project_pwm_shadow_sequencer;

    localparam int NCH = 3;
    localparam int W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [1:0]        wr_ch = '0;
    logic [1:0]        wr_idx = '0;
    logic [W-1:0]      wr_data = '0;
    logic [NCH-1:0]    arm = '0;
    logic [NCH-1:0]    abort = '0;
    logic [2*NCH-1:0]  mode = '0;
    logic [NCH-1:0]    zero = '0;
    logic [NCH-1:0]    period = '0;
    logic [4*W*NCH-1:0] cmp;
    logic [2*NCH-1:0]  state;
    logic [NCH-1:0]    done;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 0;

    project_pwm_shadow_sequencer #(.NUM_CH(NCH), .WIDTH(W)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_ch      (wr_ch),
        .i_wr_idx     (wr_idx),
        .i_wr_data    (wr_data),
        .i_arm        (arm),
        .i_abort      (abort),
        .i_load_mode  (mode),
        .i_zero_evt   (zero),
        .i_period_evt (period),
        .o_cmp        (cmp),
        .o_state      (state),
        .o_load_done  (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [4*W*NCH-1:0] act,
                       input logic [4*W*NCH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_sh  [NCH][4];
    logic [W-1:0] m_act [NCH][4];
    bit   [3:0]   m_dirty;
    bit   [3:0]   m_armed;
    logic [NCH-1:0] m_done;
    logic           m_err;

    always @(posedge clk or posedge rst) begin
        bit acc, a, z, p;
        int ch;
        logic [1:0] md;
        if (rst) begin
            for (int c = 0; c < NCH; c++)
                for (int i = 0; i < 4; i++) begin
                    m_sh[c][i]  = '0;
                    m_act[c][i] = '0;
                end
            m_dirty = '0;
            m_armed = '0;
            m_done  = '0;
            m_err   = 1'b0;
        end else begin
            ch    = int'(wr_ch);
            acc   = wr_valid && !((ch < NCH) && m_armed[ch]);
            m_err = acc && (ch >= NCH);
            m_done = '0;
            if (acc && ch < NCH) begin
                m_sh[ch][wr_idx] = wr_data;
                m_dirty[ch] = 1'b1;
            end
            for (int c = 0; c < NCH; c++) begin
`ifdef SHADOW_SYNC_COMMIT_EN
                a = arm[c] || arm[0]; md = mode[1:0]; z = zero[0]; p = period[0];
`else
                a = arm[c]; md = mode[2*c +: 2]; z = zero[c]; p = period[c];
`endif
                if (m_armed[c]) begin
                    if (abort[c]) m_armed[c] = 1'b0;
                    else if (md == 2'b00 || (md[0] && z) || (md[1] && p)) begin
                        for (int i = 0; i < 4; i++) m_act[c][i] = m_sh[c][i];
                        m_dirty[c] = 1'b0; m_armed[c] = 1'b0; m_done[c] = 1'b1;
                    end
                end else if (a && m_dirty[c]) begin
                    if (md == 2'b00) begin
                        for (int i = 0; i < 4; i++) m_act[c][i] = m_sh[c][i];
                        m_dirty[c] = 1'b0; m_done[c] = 1'b1;
                    end else m_armed[c] = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic [4*W*NCH-1:0] ec;
        logic [2*NCH-1:0]   es;
        logic               er;
        if (run) begin
            for (int c = 0; c < NCH; c++) begin
                for (int i = 0; i < 4; i++) ec[(4*c+i)*W +: W] = m_act[c][i];
                es[2*c +: 2] = m_armed[c] ? 2'b10 : (m_dirty[c] ? 2'b01 : 2'b00);
            end
            er = !((int'(wr_ch) < NCH) && m_armed[wr_ch]);
            chk("model_cmp", cmp, ec);
            chk("model_state", {186'd0, state}, {186'd0, es});
            chk("model_done", {189'd0, done}, {189'd0, m_done});
            chk("model_err", {191'd0, err}, {191'd0, m_err});
            chk("model_ready", {191'd0, wr_ready}, {191'd0, er});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clr();
        wr_valid = 0; arm = '0; abort = '0; zero = '0; period = '0;
    endtask

    task automatic write1(input int c, input int i, input logic [W-1:0] d);
        wr_valid = 1; wr_ch = 2'(c); wr_idx = 2'(i); wr_data = d;
        step();
        wr_valid = 0;
    endtask

    task automatic arm1(input int c);
        arm[c] = 1'b1;
        step();
        arm = '0;
    endtask

    function automatic logic [W-1:0] getc(input int c, input int i);
        return cmp[(4*c+i)*W +: W];
    endfunction

    logic [4*W*NCH-1:0] saved;
    int cnt;

    initial begin
        #1 rst = 1; run = 1;
        repeat (3) step();
        rst = 0;
        step();

        // Immediate load, then reset while more data is pending.
        write1(0, 0, 16'h1111);
        write1(0, 1, 16'h2222);
        arm1(0);
        chk("imm_ch0_a", {176'd0, getc(0, 0)}, {176'd0, 16'h1111});
        chk("imm_ch0_b", {176'd0, getc(0, 1)}, {176'd0, 16'h2222});
        write1(0, 2, 16'h3333);
        write1(1, 0, 16'h4444);
        rst = 1; #1;
        chk("rst_cmp", cmp, '0);
        chk("rst_state", {186'd0, state}, '0);
        chk("rst_ready", {191'd0, wr_ready}, 192'd1);
        step();
        rst = 0;
        step();

`ifdef SHADOW_SYNC_COMMIT_EN
        mode = {2'b10, 2'b10, 2'b01};
        write1(0, 0, 16'h0A0A);
        write1(1, 0, 16'h1B1B);
        write1(2, 0, 16'h2C2C);
        arm1(0);
        chk("sync_armed", {186'd0, state}, {186'd0, 6'b101010});
        zero[1] = 1; period[1] = 1; step(); clr();
        chk("sync_ch1_evt_ignored", {176'd0, getc(1, 0)}, '0);
        zero[0] = 1; step(); clr();
        chk("sync_done", {189'd0, done}, {189'd0, 3'b111});
        chk("sync_ch0", {176'd0, getc(0, 0)}, {176'd0, 16'h0A0A});
        chk("sync_ch1", {176'd0, getc(1, 0)}, {176'd0, 16'h1B1B});
        chk("sync_ch2", {176'd0, getc(2, 0)}, {176'd0, 16'h2C2C});
`else
        // Ch0 mode zero: period ignored, zero pulse loads one cycle later.
        mode[1:0] = 2'b01;
        write1(0, 0, 16'h0100);
        arm1(0);
        chk("ch0_armed", {190'd0, state[1:0]}, {190'd0, 2'b10});
        step();
        period[0] = 1; step(); clr();
        chk("ch0_period_ignored", {176'd0, getc(0, 0)}, '0);
        zero[0] = 1; #1;
        chk("ch0_before_load", {176'd0, getc(0, 0)}, '0);
        step(); clr();
        chk("ch0_after_load", {176'd0, getc(0, 0)}, {176'd0, 16'h0100});
        chk("ch0_done", {191'd0, done[0]}, 192'd1);
        step();
        chk("ch0_done_single", {191'd0, done[0]}, '0);

        // Ch1 mode period: held write stalls until the load.
        mode[3:2] = 2'b10;
        write1(1, 2, 16'hBEEF);
        arm1(1);
        wr_valid = 1; wr_ch = 2'd1; wr_idx = 2'd3; wr_data = 16'h1234; #1;
        chk("ch1_stall", {191'd0, wr_ready}, '0);
        step(); step();
        chk("ch1_stall_held", {191'd0, wr_ready}, '0);
        period[1] = 1; step(); period = '0;
        chk("ch1_ready_after", {191'd0, wr_ready}, 192'd1);
        chk("ch1_loaded", {176'd0, getc(1, 2)}, {176'd0, 16'hBEEF});
        chk("ch1_idx3_old", {176'd0, getc(1, 3)}, '0);
        step(); wr_valid = 0;
        chk("ch1_pending", {190'd0, state[3:2]}, {190'd0, 2'b01});
        arm1(1);
        period[1] = 1; step(); clr();
        chk("ch1_idx3_new", {176'd0, getc(1, 3)}, {176'd0, 16'h1234});

        // Ch2 mode both: coincident events give one load; abort beats event.
        mode[5:4] = 2'b11;
        write1(2, 0, 16'hAAAA);
        arm1(2);
        zero[2] = 1; period[2] = 1; step(); clr();
        cnt = 0;
        repeat (4) begin cnt += int'(done[2]); step(); end
        chk("ch2_one_load", 192'(cnt), 192'd1);
        chk("ch2_val", {176'd0, getc(2, 0)}, {176'd0, 16'hAAAA});
        write1(2, 1, 16'h5555);
        arm1(2);
        abort[2] = 1; zero[2] = 1; step(); clr();
        chk("ch2_abort_state", {190'd0, state[5:4]}, {190'd0, 2'b01});
        chk("ch2_abort_noload", {176'd0, getc(2, 1)}, '0);
        arm1(2);
        zero[2] = 1; step(); clr();
        chk("ch2_rearm_load", {176'd0, getc(2, 1)}, {176'd0, 16'h5555});

        // Invalid channel write.
        saved = cmp;
        wr_valid = 1; wr_ch = 2'd3; wr_idx = 2'd0; wr_data = 16'hDEAD; #1;
        chk("badch_ready", {191'd0, wr_ready}, 192'd1);
        step(); wr_valid = 0;
        chk("badch_err", {191'd0, err}, 192'd1);
        chk("badch_nochange", cmp, saved);
        step();
        chk("badch_err_single", {191'd0, err}, '0);

        // Arm in IDLE is ignored.
        arm1(1);
        chk("idle_arm_ignored", {190'd0, state[3:2]}, '0);

        // Write and immediate arm in the same cycle commit the new data.
        mode[1:0] = 2'b00;
        wr_valid = 1; wr_ch = 2'd0; wr_idx = 2'd1; wr_data = 16'h7777; arm[0] = 1;
        step(); clr();
        chk("wr_arm_same", {176'd0, getc(0, 1)}, {176'd0, 16'h7777});
        chk("wr_arm_done", {191'd0, done[0]}, 192'd1);

        // Events in PENDING are ignored.
        mode[1:0] = 2'b01;
        write1(0, 3, 16'h9999);
        zero[0] = 1; step(); clr();
        chk("pending_evt_ignored", {176'd0, getc(0, 3)}, '0);
        chk("pending_state", {190'd0, state[1:0]}, {190'd0, 2'b01});
`endif
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/project_pwm_shadow_sequencer.md
Name: project_pwm_shadow_sequencer

Overview:
- Double-buffers the compare A/B values of all PWM channels (channel 1/2/3, outputs A and B).
- The host writes pending values into shadow registers. The active compare values seen by the comparators change only at a counter event (zero and/or period) selected per channel. This guarantees glitch-free duty updates.
- Sits between the register file / host interface and the comparator instances. It is fed by the zero/period pulses of the master and slave period counters.

Parameters:
- NUM_CH, 3, number of PWM channels (counter instances).
- WIDTH, 16, compare value width in bits.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  asynchronous active-high reset.
- i_wr_valid  input  1  host shadow-write request.
- o_wr_ready  output  1  shadow write accepted this cycle when high together with i_wr_valid.
- i_wr_ch  input  2  target channel 0..NUM_CH-1.
- i_wr_idx  input  2  0=A.compa, 1=A.compb, 2=B.compa, 3=B.compb.
- i_wr_data  input  WIDTH  value to write.
- i_arm  input  NUM_CH  per-channel commit request (single-cycle pulse).
- i_abort  input  NUM_CH  per-channel cancel of an armed commit.
- i_load_mode  input  2*NUM_CH  per channel: 00 immediate, 01 at zero, 10 at period, 11 at zero or period.
- i_zero_evt  input  NUM_CH  counter-reached-zero pulse per channel.
- i_period_evt  input  NUM_CH  counter-reached-period pulse per channel.
- o_cmp  output  4*WIDTH*NUM_CH  active compare values; channel c, index i at bits [(4c+i)*WIDTH +: WIDTH].
- o_state  output  2*NUM_CH  per-channel state encoding.
- o_load_done  output  NUM_CH  single-cycle pulse when active registers update.
- o_err  output  1  single-cycle pulse on a write to an invalid channel.

Behaviour:
- Reset (async, active high):
  - All shadow and active registers are 0.
  - All channels go to IDLE.
  - o_load_done=0, o_err=0, o_wr_ready=1.
  - Reset mid-commit discards pending data.
- Per-channel FSM (o_state encoding):
  - IDLE (00): shadow equals active.
  - PENDING (01): at least one shadow write since the last load.
  - ARMED (10): commit requested, waiting for the event.
- Transitions:
  - IDLE -> PENDING on an accepted write to that channel.
  - PENDING -> ARMED on i_arm when mode != 00.
  - PENDING with i_arm and mode 00: load at the next edge; active valid at t+1; o_load_done pulses at t+1; -> IDLE.
  - ARMED -> IDLE on a qualifying event at cycle t: all four shadows copied to active at t+1; o_load_done pulses at t+1.
  - ARMED -> PENDING on i_abort (abort wins over a same-cycle event).
  - i_arm in IDLE or ARMED is ignored.
  - i_load_mode is sampled continuously while ARMED.
- Write handshake:
  - o_wr_ready = 0 only when the addressed channel is ARMED. Writes are never dropped while a load is pending; the host must hold i_wr_valid.
  - A write with i_wr_ch >= NUM_CH is accepted (ready=1), discarded, and o_err pulses next cycle.
- Same-cycle events:
  - Write + i_arm on the same channel in PENDING or IDLE: the write lands in the shadow first, then the arm takes effect; the new data is included in the commit.
  - Zero and period events together in mode 11 produce a single load.
- Events arriving in IDLE or PENDING are ignored.
- Shadows are only ever overwritten by host writes, so a load copies the last written value even for unwritten indices.
- No arithmetic; all values are stored WIDTH-bit unsigned, with no width conversion.

Optional Feature:
- SHADOW_SYNC_COMMIT_EN
  - Defined:
    - i_arm[0] also arms every channel in PENDING.
    - All armed channels load together on channel 0's qualifying event, using channel 0's mode. Their own events are ignored.
    - Intended for phase-locked multi-phase duty updates.
  - Undefined: channels are fully independent as described above.

Decomposition:
- Shared package holds:
  - State encodings ST_IDLE/ST_PENDING/ST_ARMED.
  - Load-mode constants LM_IMM/LM_ZERO/LM_PERIOD/LM_BOTH.
  - Compare-index constants IDX_ACMPA..IDX_BCMPB.
- One natural sub-module, project_pwm_shadow_channel, instantiated NUM_CH times. Per channel it holds the FSM, four shadow and four active registers, and the event qualification.
- The top level does write decoding, ready/err generation and the optional sync-commit fan-out.

Test Plan:
- Reset with non-zero shadows loaded -> o_cmp all 0, o_state all 00, o_wr_ready=1.
- Write ch0 idx0=0x0100, arm in mode 01, zero pulse at cycle 20 -> o_cmp ch0 A.compa stays 0 until cycle 21, then reads 0x0100; o_load_done[0] pulses at cycle 21.
- Ch1 ARMED in mode 10; write ch1 while i_wr_valid is held -> o_wr_ready=0 until period pulse at t, then ready=1 at t+1 and the write is accepted into shadow.
- Ch2 mode 11 with zero and period pulses in the same cycle -> exactly one o_load_done[2] pulse; i_abort together with an event -> no load, state returns to 01.
- Write to i_wr_ch=3 -> o_err pulses once, no o_cmp change.
- With SHADOW_SYNC_COMMIT_EN: ch0/ch1/ch2 PENDING, arm ch0 only in mode 01, ch0 zero pulse -> all three channels' o_cmp update in the same cycle; ch1 zero pulses alone cause no load.
